// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the sequential execution unit.
//   op_t     - operation codes carried on in_op
//   state_t  - control FSM states of alu_seq
//   OP_IS_MULDIV - bit of in_op that selects the iterative multiply/divide group
package alu_pkg;

   typedef enum logic [4:0] {
      OP_ADD    = 5'd0,
      OP_SUB    = 5'd1,
      OP_AND    = 5'd2,
      OP_OR     = 5'd3,
      OP_XOR    = 5'd4,
      OP_SLL    = 5'd5,
      OP_SRL    = 5'd6,
      OP_SRA    = 5'd7,
      OP_SLT    = 5'd8,
      OP_SLTU   = 5'd9,
      OP_PASSB  = 5'd10,
      OP_MUL    = 5'd16,
      OP_MULH   = 5'd17,
      OP_MULHSU = 5'd18,
      OP_MULHU  = 5'd19,
      OP_DIV    = 5'd20,
      OP_DIVU   = 5'd21,
      OP_REM    = 5'd22,
      OP_REMU   = 5'd23
   } op_t;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MUL  = 2'd1,
      S_DIV  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   localparam int OP_IS_MULDIV = 4;

   // Codes 24..31 also have bit 4 set but are undefined, so bit 3 must be clear.
   function automatic logic is_muldiv(input logic [4:0] op);
      return op[OP_IS_MULDIV] & ~op[3];
   endfunction

endpackage

// File: rtl/alu_seq_if.sv
// alu_seq_if: request/result handshake bundle of alu_seq.
//   in_valid/in_ready/in_op/in_a/in_b/in_tag    - request channel
//   out_valid/out_ready/out_d/out_tag           - result channel
//   master: requester + result consumer; slave: the execution unit
interface alu_seq_if #(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [4:0]       in_op;
   logic [XLEN-1:0]  in_a;
   logic [XLEN-1:0]  in_b;
   logic [TAG_W-1:0] in_tag;
   logic             out_valid;
   logic             out_ready;
   logic [XLEN-1:0]  out_d;
   logic [TAG_W-1:0] out_tag;

   modport master (
      output in_valid, in_op, in_a, in_b, in_tag, out_ready,
      input  in_ready, out_valid, out_d, out_tag
   );

   modport slave (
      input  in_valid, in_op, in_a, in_b, in_tag, out_ready,
      output in_ready, out_valid, out_d, out_tag
   );
endinterface

// File: rtl/alu_comb.sv
// alu_comb: single-cycle integer operations (ADD..PASSB); any other code gives 0.
//   op - operation code, a/b - operands, y - result
module alu_comb
   import alu_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [4:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   output logic [XLEN-1:0] y
);
   localparam int SH_W = $clog2(XLEN);
   localparam logic [XLEN-1:0] MSB = {1'b1, {(XLEN-1){1'b0}}};

   logic [SH_W-1:0] sh;

   assign sh = b[SH_W-1:0];

   always_comb begin
      y = '0;
      case (op)
         OP_ADD:   y = a + b;
         OP_SUB:   y = a - b;
         OP_AND:   y = a & b;
         OP_OR:    y = a | b;
         OP_XOR:   y = a ^ b;
         OP_SLL:   y = a << sh;
         OP_SRL:   y = a >> sh;
         OP_SRA:   y = $signed(a) >>> sh;
         // flipping the sign bit turns a signed compare into an unsigned one
         OP_SLT:   y = {{(XLEN-1){1'b0}}, ((a ^ MSB) < (b ^ MSB))};
         OP_SLTU:  y = {{(XLEN-1){1'b0}}, (a < b)};
         OP_PASSB: y = b;
         default:  y = '0;
      endcase
   end
endmodule

// File: rtl/alu_seq.sv
// alu_seq: sequential execution unit (single-cycle ALU + iterative mul/div).
//   clk, rst - clock and asynchronous active-high reset
//   bus      - alu_seq_if slave: request in, tagged result out (held until consumed)
//
// state | meaning
// IDLE  | no result held, ready for a request
// MUL   | shift-add multiply iterating, one multiplier bit per cycle
// DIV   | restoring divide iterating, one quotient bit per cycle
// DONE  | result register holds an unconsumed result
module alu_seq
   import alu_pkg::*;
#(
   parameter int XLEN  = 32,
   parameter int TAG_W = 5
) (
   input  logic     clk,
   input  logic     rst,
   alu_seq_if.slave bus
);
   localparam int CNT_W = $clog2(XLEN) + 1;
   localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt;
   logic [4:0]         op_q;
   logic [TAG_W-1:0]   tag_q;
   logic [2*XLEN-1:0]  acc, acc_step, prod;
   logic [XLEN-1:0]    opd;
   logic               neg_p, neg_r;

   logic               accept, in_muldiv, in_div, a_neg, b_neg, special;
   logic [XLEN-1:0]    mag_a, mag_b, comb_y, special_y, fin_y, quo, rmd, out_nxt;
   logic [TAG_W-1:0]   out_tag_nxt;
   logic               out_load;
   logic [XLEN:0]      mul_sum, div_shift, div_diff;
   logic               div_ge;

   assign bus.in_ready  = (state == S_IDLE) || (state == S_DONE && bus.out_ready);
   assign bus.out_valid = (state == S_DONE);
   assign accept        = bus.in_valid && bus.in_ready;

   alu_comb #(.XLEN(XLEN)) u_comb (
      .op (bus.in_op),
      .a  (bus.in_a),
      .b  (bus.in_b),
      .y  (comb_y)
   );

   // request decode: operand magnitudes, signs and divide special cases
   always_comb begin
      in_muldiv = is_muldiv(bus.in_op);
      in_div    = bus.in_op[2];
      a_neg     = 1'b0;
      b_neg     = 1'b0;
      case (bus.in_op)
         OP_MULH, OP_DIV, OP_REM: begin
            a_neg = bus.in_a[XLEN-1];
            b_neg = bus.in_b[XLEN-1];
         end
         OP_MULHSU: a_neg = bus.in_a[XLEN-1];
         default: ;
      endcase
      mag_a = a_neg ? -bus.in_a : bus.in_a;
      mag_b = b_neg ? -bus.in_b : bus.in_b;

      // op[1] selects remainder, op[0] clear marks the signed variants
      special   = 1'b0;
      special_y = '0;
      if (in_muldiv && in_div) begin
         if (bus.in_b == '0) begin
            special   = 1'b1;
            special_y = bus.in_op[1] ? bus.in_a : '1;
         end else if (!bus.in_op[0] && bus.in_a == MIN_VAL && bus.in_b == '1) begin
            special   = 1'b1;
            special_y = bus.in_op[1] ? '0 : MIN_VAL;
         end
      end
   end

   // one iteration of the multiply or divide, plus the signed fix-up of its result
   always_comb begin
      mul_sum   = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
      div_shift = acc[2*XLEN-1:XLEN-1];
      div_diff  = div_shift - {1'b0, opd};
      div_ge    = (div_shift >= {1'b0, opd});
      if (state == S_DIV)
         acc_step = {(div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0]),
                     acc[XLEN-2:0], div_ge};
      else
         acc_step = {mul_sum, acc[XLEN-1:1]};

      prod = neg_p ? -acc_step : acc_step;
      quo  = neg_p ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rmd  = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      if (state == S_MUL)
         fin_y = (op_q == OP_MUL) ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN];
      else
         fin_y = op_q[1] ? rmd : quo;
   end

   always_comb begin
      state_nxt   = state;
      out_load    = 1'b0;
      out_nxt     = comb_y;
      out_tag_nxt = bus.in_tag;
      case (state)
         S_IDLE, S_DONE: begin
            if (accept) begin
               if (in_muldiv && !special) begin
                  state_nxt = in_div ? S_DIV : S_MUL;
               end else begin
                  state_nxt = S_DONE;
                  out_load  = 1'b1;
                  out_nxt   = in_muldiv ? special_y : comb_y;
               end
            end else if (state == S_DONE && bus.out_ready) begin
               state_nxt = S_IDLE;
            end
         end
         S_MUL, S_DIV: begin
            // the last iteration's result goes straight to the output register
            if (cnt == '0) begin
               state_nxt   = S_DONE;
               out_load    = 1'b1;
               out_nxt     = fin_y;
               out_tag_nxt = tag_q;
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_IDLE;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt         <= '0;
         op_q        <= '0;
         tag_q       <= '0;
         acc         <= '0;
         opd         <= '0;
         neg_p       <= 1'b0;
         neg_r       <= 1'b0;
         bus.out_d   <= '0;
         bus.out_tag <= '0;
      end else begin
         if (accept) begin
            op_q  <= bus.in_op;
            tag_q <= bus.in_tag;
            cnt   <= CNT_W'(XLEN - 1);
            neg_p <= a_neg ^ b_neg;
            neg_r <= a_neg;
            // divide shifts the dividend out of the low half; multiply shifts the multiplier
            if (in_div) begin
               acc <= {{XLEN{1'b0}}, mag_a};
               opd <= mag_b;
            end else begin
               acc <= {{XLEN{1'b0}}, mag_b};
               opd <= mag_a;
            end
         end else if (state == S_MUL || state == S_DIV) begin
            acc <= acc_step;
            if (cnt != '0) cnt <= cnt - 1'b1;
         end
         if (out_load) begin
            bus.out_d   <= out_nxt;
            bus.out_tag <= out_tag_nxt;
         end
      end
   end
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed self-checking bench for alu_seq (XLEN=32, TAG_W=5).
module tb_alu_seq;
   import alu_pkg::*;

   localparam int XLEN  = 32;
   localparam int TAG_W = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_pass  = 0;
   int   n_total = 0;

   always #5 clk = ~clk;

   alu_seq_if #(.XLEN(XLEN), .TAG_W(TAG_W)) bus ();

   alu_seq #(.XLEN(XLEN), .TAG_W(TAG_W)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // present one request, wait for acceptance, then count edges until out_valid
   task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [4:0] tag, output logic [31:0] d,
                        output logic [4:0] tg, output int lat);
      int w;
      w = 0;
      bus.in_op    = op;
      bus.in_a     = a;
      bus.in_b     = b;
      bus.in_tag   = tag;
      bus.in_valid = 1'b1;
      while (!bus.in_ready && w < 50) begin
         tick();
         w++;
      end
      tick();
      bus.in_valid = 1'b0;
      lat = 1;
      while (!bus.out_valid && lat < 100) begin
         tick();
         lat++;
      end
      d  = bus.out_d;
      tg = bus.out_tag;
   endtask

   task automatic consume();
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
   endtask

   task automatic test_reset();
      repeat (3) tick();
      n_total++;
      if ({bus.out_valid, bus.out_tag, bus.out_d} !== 38'd0)
         $display("FAIL reset_outputs got valid=%b tag=%h d=%h want all 0",
                  bus.out_valid, bus.out_tag, bus.out_d);
      else n_pass++;
      rst = 1'b0;
      tick();
      n_total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL reset_release got in_ready=%b out_valid=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_alu();
      logic [4:0]  ops [13];
      logic [31:0] va  [13];
      logic [31:0] vb  [13];
      logic [31:0] ve  [13];
      logic [31:0] d;
      logic [4:0]  tg;
      int          lat;
      ops = '{OP_ADD, OP_SUB, OP_SRA, OP_SLT, OP_SLTU, OP_SLL, OP_SRL,
              OP_XOR, OP_AND, OP_OR, OP_PASSB, 5'd13, 5'd25};
      va  = '{32'h7FFF_FFFF, 32'h0, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
              32'h1, 32'h8000_0000, 32'hF0F0, 32'hF0F0, 32'hF0F0, 32'h1234,
              32'h5, 32'h5};
      vb  = '{32'h1, 32'h1, 32'd31, 32'h1, 32'h1, 32'd33, 32'd4,
              32'hFF00, 32'hFF00, 32'hFF00, 32'hCAFE_F00D, 32'h3, 32'h3};
      ve  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h1, 32'h0,
              32'h2, 32'h0800_0000, 32'h0FF0, 32'hF000, 32'hFFF0, 32'hCAFE_F00D,
              32'h0, 32'h0};
      for (int i = 0; i < 13; i++) begin
         issue(ops[i], va[i], vb[i], 5'(i + 3), d, tg, lat);
         n_total++;
         if (d !== ve[i] || tg !== 5'(i + 3) || lat != 1)
            $display("FAIL alu_op%0d got d=%h tag=%0d lat=%0d want d=%h tag=%0d lat=1",
                     ops[i], d, tg, lat, ve[i], i + 3);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_mul();
      logic [4:0]  ops [5];
      logic [31:0] va  [5];
      logic [31:0] vb  [5];
      logic [31:0] ve  [5];
      logic [31:0] d;
      logic [4:0]  tg;
      int          lat;
      ops = '{OP_MULH, OP_MULHU, OP_MUL, OP_MULHSU, OP_MULHU};
      va  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h0001_0000};
      vb  = '{32'h8000_0000, 32'hFFFF_FFFF, 32'd7, 32'd2, 32'h0001_0000};
      ve  = '{32'h4000_0000, 32'hFFFF_FFFE, 32'hFFFF_FFEB, 32'hFFFF_FFFF, 32'h1};
      for (int i = 0; i < 5; i++) begin
         issue(ops[i], va[i], vb[i], 5'(20 + i), d, tg, lat);
         n_total++;
         if (d !== ve[i] || tg !== 5'(20 + i) || lat != 33)
            $display("FAIL mul_op%0d got d=%h tag=%0d lat=%0d want d=%h tag=%0d lat=33",
                     ops[i], d, tg, lat, ve[i], 20 + i);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_div();
      logic [4:0]  ops [9];
      logic [31:0] va  [9];
      logic [31:0] vb  [9];
      logic [31:0] ve  [9];
      int          vl  [9];
      logic [31:0] d;
      logic [4:0]  tg;
      int          lat;
      ops = '{OP_DIV, OP_REM, OP_DIVU, OP_REMU, OP_DIVU, OP_REM, OP_DIV, OP_REM, OP_DIVU};
      va  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd5, 32'd5,
              32'h8000_0000, 32'h8000_0000, 32'h8000_0000};
      vb  = '{32'd2, 32'd2, 32'd7, 32'd7, 32'd0, 32'd0,
              32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
      ve  = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFF, 32'd5,
              32'h8000_0000, 32'h0, 32'h0};
      vl  = '{33, 33, 33, 33, 1, 1, 1, 1, 33};
      for (int i = 0; i < 9; i++) begin
         issue(ops[i], va[i], vb[i], 5'(i), d, tg, lat);
         n_total++;
         if (d !== ve[i] || tg !== 5'(i) || lat != vl[i])
            $display("FAIL div_op%0d_%0d got d=%h tag=%0d lat=%0d want d=%h tag=%0d lat=%0d",
                     ops[i], i, d, tg, lat, ve[i], i, vl[i]);
         else n_pass++;
         consume();
      end
   endtask

   task automatic test_backpressure();
      logic [31:0] d;
      logic [4:0]  tg;
      int          lat;
      issue(OP_ADD, 32'h11, 32'h22, 5'd9, d, tg, lat);
      n_total++;
      if (d !== 32'h33 || tg !== 5'd9 || lat != 1)
         $display("FAIL bp_first got d=%h tag=%0d lat=%0d want 33/9/1", d, tg, lat);
      else n_pass++;
      for (int i = 0; i < 10; i++) begin
         tick();
         n_total++;
         if ({bus.out_valid, bus.in_ready, bus.out_tag, bus.out_d} !== {1'b1, 1'b0, 5'd9, 32'h33})
            $display("FAIL bp_hold%0d got valid=%b in_ready=%b tag=%0d d=%h want 1/0/9/33",
                     i, bus.out_valid, bus.in_ready, bus.out_tag, bus.out_d);
         else n_pass++;
      end
      bus.in_op     = OP_ADD;
      bus.in_a      = 32'd3;
      bus.in_b      = 32'd4;
      bus.in_tag    = 5'd10;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b1;
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1)
         $display("FAIL bp_ready_follow got in_ready=%b want 1", bus.in_ready);
      else n_pass++;
      tick();
      bus.in_valid = 1'b0;
      n_total++;
      if ({bus.out_valid, bus.out_tag, bus.out_d} !== {1'b1, 5'd10, 32'd7})
         $display("FAIL bp_swap got valid=%b tag=%0d d=%h want 1/10/7",
                  bus.out_valid, bus.out_tag, bus.out_d);
      else n_pass++;
      tick();
      bus.out_ready = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL bp_drain got out_valid=%b want 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_back_to_back();
      bus.out_ready = 1'b1;
      bus.in_op     = OP_ADD;
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 8; i++) begin
         bus.in_a   = 32'(i);
         bus.in_b   = 32'd100;
         bus.in_tag = 5'(i);
         tick();
         n_total++;
         if ({bus.out_valid, bus.out_tag, bus.out_d} !== {1'b1, 5'(i), 32'(i + 100)})
            $display("FAIL b2b_%0d got valid=%b tag=%0d d=%0d want 1/%0d/%0d",
                     i, bus.out_valid, bus.out_tag, bus.out_d, i, i + 100);
         else n_pass++;
      end
      bus.in_valid = 1'b0;
      tick();
      bus.out_ready = 1'b0;
      n_total++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL b2b_drain got out_valid=%b want 0", bus.out_valid);
      else n_pass++;
   endtask

   task automatic test_reset_mid();
      logic [31:0] d;
      logic [4:0]  tg;
      int          lat;
      int          seen;
      bus.in_op    = OP_DIV;
      bus.in_a     = 32'd1000;
      bus.in_b     = 32'd3;
      bus.in_tag   = 5'd17;
      bus.in_valid = 1'b1;
      tick();
      bus.in_valid = 1'b0;
      repeat (14) tick();
      rst = 1'b1;
      #1;
      n_total++;
      if (bus.out_valid !== 1'b0)
         $display("FAIL rst_mid_valid got out_valid=%b want 0", bus.out_valid);
      else n_pass++;
      tick();
      rst = 1'b0;
      #1;
      n_total++;
      if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0)
         $display("FAIL rst_mid_release got in_ready=%b out_valid=%b want 1/0",
                  bus.in_ready, bus.out_valid);
      else n_pass++;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
         tick();
         if (bus.out_valid) seen++;
      end
      n_total++;
      if (seen != 0)
         $display("FAIL rst_mid_abandon got %0d valid cycles want 0", seen);
      else n_pass++;
      issue(OP_ADD, 32'd2, 32'd2, 5'd6, d, tg, lat);
      n_total++;
      if (d !== 32'd4 || tg !== 5'd6 || lat != 1)
         $display("FAIL rst_mid_add got d=%h tag=%0d lat=%0d want 4/6/1", d, tg, lat);
      else n_pass++;
      consume();
   endtask

   initial begin
      bus.in_valid  = 1'b0;
      bus.in_op     = '0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.in_tag    = '0;
      bus.out_ready = 1'b0;
      test_reset();
      test_alu();
      test_mul();
      test_div();
      test_backpressure();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog simulation time limit reached, passed %0d of %0d", n_pass, n_total);
      $fatal(1);
   end
endmodule

// File: doc/alu_seq.md
# alu_seq

Parametrised sequential execution unit for the core's execute stage. It merges the base integer ALU operations with an iterative RV32M-style multiply/divide path behind a valid/ready handshake. Every result carries a caller tag and is held in an output register until consumed.

## Interface
- XLEN, 32: datapath width; power of two, ≥ 8
- TAG_W, 5: width of the pass-through tag (e.g. destination register)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- in_valid  in  1  request present
- in_ready  out  1  unit can accept a request this cycle
- in_op  in  5  operation code (alu_pkg::op_t)
- in_a, in_b  in  XLEN  operands
- in_tag  in  TAG_W  returned unchanged with the result
- out_valid  out  1  result register holds an unconsumed result
- out_ready  in  1  consumer takes the result this cycle
- out_d  out  XLEN  result
- out_tag  out  TAG_W  tag of the result

## Operation
- Op codes:
  - ADD=0, SUB=1, AND=2, OR=3, XOR=4, SLL=5, SRL=6, SRA=7, SLT=8, SLTU=9, PASSB=10
  - MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23
  - Any other code: single-cycle op, result 0.
- Shift amount is in_b[$clog2(XLEN)-1:0]. SRA fills with a[XLEN-1].
- SLT compares with the sign bit flipped on both operands; the result is zero-extended 0/1.
- Accept condition: in_valid && in_ready. The op, operands and tag are captured on that edge.
- FSM states: IDLE, MUL, DIV, DONE.
  - IDLE → DONE for single-cycle ops and for divide special cases.
  - IDLE → MUL for MUL* ops; IDLE → DIV for DIV*/REM* ops.
  - MUL/DIV → DONE after the last iteration.
  - DONE → IDLE on out_ready, or DONE → MUL/DIV/DONE if a new request is accepted in the same cycle.
- in_ready = (state==IDLE) || (state==DONE && out_ready).
- out_valid = (state==DONE).
- MUL*: operands are converted to magnitudes per signedness (MULH both signed, MULHSU a signed only). Shift-add runs one bit per cycle for XLEN cycles into a 2·XLEN accumulator. The product is negated at the end if the signs differ. MUL returns the low half; the others return the high half.
- DIV*/REM*: restoring division on magnitudes, one quotient bit per cycle, XLEN cycles. Quotient sign = sign(a) xor sign(b); remainder sign = sign(a).
- Divide special cases, resolved at accept without iterating:
  - b==0: quotient all-ones, remainder = a.
  - Signed a==MIN and b==−1: quotient MIN, remainder 0.
- The output register is written only on the transition into DONE and is stable while out_valid && !out_ready.

## Timing
- Reset: state IDLE, out_valid 0, out_d 0, out_tag 0; in_ready 1 once rst deasserts.
- Single-cycle ops and divide special cases: out_valid rises on the edge after accept (latency 1).
- MUL*/DIV*/REM*: out_valid rises XLEN+1 edges after accept (33 for XLEN=32).
- Throughput: one single-cycle op per clock while out_ready is held high.
- Backpressure: DONE holds indefinitely; in_ready stays 0 until out_ready.
- Reset mid-operation abandons the operation and no result is produced. The first accept after reset behaves as from IDLE.
- Simultaneous out_ready and in_valid in DONE: the old result is consumed and the new request is accepted on the same edge.

## Structure
- Package alu_pkg:
  - op_t enum with the codes above.
  - state_t enum.
  - Helper constant OP_IS_MULDIV (in_op[4]).
- Sub-module alu_comb: purely combinational single-cycle ops (ADD…PASSB and the undefined-op default), parametrised by XLEN.
- alu_seq contains the FSM, iteration counter ($clog2(XLEN)+1 bits), the multiply/divide datapath and the output register.

## Test plan
- ADD 0x7FFFFFFF + 1 → out_d 0x80000000 one cycle after accept. SUB 0 − 1 → 0xFFFFFFFF. SRA 0x80000000 by 31 → 0xFFFFFFFF. SLT −1 < 1 → 1; SLTU same operands → 0.
- MULH 0x80000000 × 0x80000000 → 0x40000000. MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE. MUL −3 × 7 → 0xFFFFFFEB. All with out_valid exactly 33 edges after accept.
- DIV −7/2 → 0xFFFFFFFD, REM −7/2 → 0xFFFFFFFF. DIVU 5/0 → 0xFFFFFFFF and REM 5/0 → 5 at latency 1. DIV 0x80000000/−1 → 0x80000000, REM → 0.
- Backpressure: out_ready low for 10 cycles after a result → out_d and out_tag stable, in_ready 0. Raise out_ready with a new ADD pending → both handshakes complete on the same edge.
- Back-to-back: 8 ADDs with tags 0–7 and out_ready tied high → one result per cycle, tags in order.
- Assert rst at iteration 15 of a DIV → out_valid 0 and in_ready 1 after release. A following ADD 2+2 → 4 at latency 1.
